sd_cmd: RTL and testbench

//  SD card CMD line engine. Serializes a 48-bit command frame and deserializes a 48-bit

---
 rtl/sd_cmd.sv | 204 ++++++++++++++++++++
 tb/tb_sd_cmd.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd.sv
// SD card CMD line engine: 48-bit command serializer and response deserializer driven by SD clock strobes.
// Optional macro SD_CMD_CRC_CHECK_EN enables the response CRC7 check; the TX CRC7 is always generated.
module sd_cmd #(
  parameter int TIMEOUT_CLOCKS = 64,
  parameter int GAP_CLOCKS     = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_clk_strobe_rising,
  input  logic        i_sd_clk_strobe_falling,
  output logic        o_sd_cmd_oe,
  output logic        o_sd_cmd_out,
  input  logic        i_sd_cmd_in,
  input  logic        i_command_start,
  input  logic [5:0]  i_command_index,
  input  logic [31:0] i_command_arg,
  input  logic        i_command_skip_response,
  output logic        o_command_busy,
  output logic        o_command_done,
  output logic        o_command_timeout,
  output logic        o_command_crc_error,
  output logic        o_command_index_error,
  output logic [5:0]  o_response_index,
  output logic [31:0] o_response_arg
);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_GAP} state_t;

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t             state, state_next;
  logic [47:0]        tx_sr;
  logic [45:0]        rx_sr;
  logic [46:0]        rx_full;
  logic [5:0]         bit_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         index_q;
  logic               skip_q;
  logic               rise, fall;
  logic               accept, tx_drive, tx_release, rx_start, rx_shift, rx_last;
  logic               wait_tick, timeout_hit, gap_tick, gap_end;
  logic               rx_crc_bad;
  logic [39:0]        tx_body;

  // Falling strobe loses if both strobes ever coincide.
  assign rise    = i_sd_clk_strobe_rising;
  assign fall    = i_sd_clk_strobe_falling & ~i_sd_clk_strobe_rising;
  assign tx_body = {2'b01, i_command_index, i_command_arg};
  assign rx_full = {rx_sr, i_sd_cmd_in};

`ifdef SD_CMD_CRC_CHECK_EN
  assign rx_crc_bad = (crc7({1'b0, rx_full[46:8]}) != rx_full[7:1]) || !rx_full[0];
`else
  logic rx_unused;
  assign rx_crc_bad = !rx_full[0];
  assign rx_unused  = ^{rx_full[46], rx_full[7:1]};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    tx_drive    = 1'b0;
    tx_release  = 1'b0;
    rx_start    = 1'b0;
    rx_shift    = 1'b0;
    rx_last     = 1'b0;
    wait_tick   = 1'b0;
    timeout_hit = 1'b0;
    gap_tick    = 1'b0;
    gap_end     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_command_start && !o_command_busy) begin
          accept     = 1'b1;
          state_next = S_TX;
        end
      end
      S_TX: begin
        if (fall) begin
          if (bit_cnt == 6'd48) begin
            tx_release = 1'b1;
            state_next = skip_q ? S_GAP : S_WAIT;
          end else begin
            tx_drive = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rise) begin
          if (!i_sd_cmd_in) begin
            rx_start   = 1'b1;
            state_next = S_RX;
          end else if (cnt == CNT_W'(TIMEOUT_CLOCKS - 1)) begin
            timeout_hit = 1'b1;
            state_next  = S_GAP;
          end else begin
            wait_tick = 1'b1;
          end
        end
      end
      S_RX: begin
        if (rise) begin
          rx_shift = 1'b1;
          if (bit_cnt == 6'd46) begin
            rx_last    = 1'b1;
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (rise) begin
          if (cnt == CNT_W'(GAP_CLOCKS - 1)) begin
            gap_end    = 1'b1;
            state_next = S_IDLE;
          end else begin
            gap_tick = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_sd_cmd_oe           <= 1'b0;
      o_sd_cmd_out          <= 1'b1;
      o_command_busy        <= 1'b0;
      o_command_done        <= 1'b0;
      o_command_timeout     <= 1'b0;
      o_command_crc_error   <= 1'b0;
      o_command_index_error <= 1'b0;
      o_response_index      <= '0;
      o_response_arg        <= '0;
      tx_sr                 <= '0;
      rx_sr                 <= '0;
      bit_cnt               <= '0;
      cnt                   <= '0;
      index_q               <= '0;
      skip_q                <= 1'b0;
    end else begin
      o_command_done <= 1'b0;
      if (accept) begin
        tx_sr                 <= {tx_body, crc7(tx_body), 1'b1};
        bit_cnt               <= '0;
        index_q               <= i_command_index;
        skip_q                <= i_command_skip_response;
        o_command_busy        <= 1'b1;
        o_command_timeout     <= 1'b0;
        o_command_crc_error   <= 1'b0;
        o_command_index_error <= 1'b0;
      end
      if (tx_drive) begin
        o_sd_cmd_oe  <= 1'b1;
        o_sd_cmd_out <= tx_sr[47];
        tx_sr        <= {tx_sr[46:0], 1'b1};
        bit_cnt      <= bit_cnt + 6'd1;
      end
      if (tx_release) begin
        o_sd_cmd_oe  <= 1'b0;
        o_sd_cmd_out <= 1'b1;
        cnt          <= '0;
      end
      if (wait_tick) cnt <= cnt + 1'b1;
      if (timeout_hit) begin
        o_command_timeout <= 1'b1;
        cnt               <= '0;
      end
      if (rx_start) bit_cnt <= '0;
      if (rx_shift) begin
        rx_sr   <= rx_full[45:0];
        bit_cnt <= bit_cnt + 6'd1;
      end
      // Start bit was consumed in WAIT, so rx_full holds dir..end here.
      if (rx_last) begin
        o_response_index      <= rx_full[45:40];
        o_response_arg        <= rx_full[39:8];
        o_command_index_error <= (rx_full[45:40] != index_q);
        o_command_crc_error   <= rx_crc_bad;
        cnt                   <= '0;
      end
      if (gap_tick) cnt <= cnt + 1'b1;
      if (gap_end) begin
        o_command_done <= 1'b1;
        o_command_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sd_cmd.sv
// Randomized self-checking bench for sd_cmd: strobe generator, card model and frame-level reference.
module tb_sd_cmd;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_rise = 1'b0, s_fall = 1'b0;
  logic        cmd_oe, cmd_out;
  logic        cmd_in = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_skip = 1'b0;
  logic        busy, done, tmo, crc_err, idx_err;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;

  always #5 clk = ~clk;

  sd_cmd dut (
    .i_clk(clk), .i_reset(reset),
    .i_sd_clk_strobe_rising(s_rise), .i_sd_clk_strobe_falling(s_fall),
    .o_sd_cmd_oe(cmd_oe), .o_sd_cmd_out(cmd_out), .i_sd_cmd_in(cmd_in),
    .i_command_start(start), .i_command_index(cmd_index), .i_command_arg(cmd_arg),
    .i_command_skip_response(cmd_skip), .o_command_busy(busy), .o_command_done(done),
    .o_command_timeout(tmo), .o_command_crc_error(crc_err), .o_command_index_error(idx_err),
    .o_response_index(resp_index), .o_response_arg(resp_arg)
  );

`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  int          n_tests = 0, n_fail = 0;
  int          div = 2, ph = 0;
  bit          clk_run = 1'b1;
  logic [47:0] resp_word = '1;
  bit          resp_armed = 1'b0;
  int          resp_delay = 0, card_phase = 0, card_wait = 0, card_bit = 0;
  bit          oe_prev = 1'b0;
  int          rise_since_rel = 0, done_seen = 0;
  logic        tx_q[$];
  logic [5:0]  exp_ri = '0;
  logic [31:0] exp_ra = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc_model(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  // Strobe generator, pad monitor and card responder share one process to stay race-free.
  always @(negedge clk) begin
    if (clk_run) begin
      s_rise = (ph == 0);
      s_fall = (ph == div / 2);
      ph     = (ph + 1) % div;
    end else begin
      s_rise = 1'b0;
      s_fall = 1'b0;
    end
    if (s_rise && cmd_oe) tx_q.push_back(cmd_out);
    if (oe_prev && !cmd_oe) begin
      rise_since_rel = 0;
      if (resp_armed) begin
        card_phase = 1;
        card_wait  = resp_delay;
      end
    end
    oe_prev = cmd_oe;
    if (s_rise) rise_since_rel++;
    if (s_fall) begin
      if (card_phase == 3) begin
        cmd_in     = 1'b1;
        card_phase = 0;
      end
      if (card_phase == 1) begin
        if (card_wait == 0) begin
          card_phase = 2;
          card_bit   = 47;
        end else card_wait--;
      end
      if (card_phase == 2) begin
        cmd_in = resp_word[card_bit];
        if (card_bit == 0) card_phase = 3;
        else card_bit--;
      end
    end
    if (done) done_seen++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mode: 0 good reply, 1 silent card, 2 bad CRC, 3 wrong index, 4 end bit 0, 5 random index/dir
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit skip,
                         input int mode, input bit poke, input bit stall,
                         input logic [31:0] rarg_in, output logic [47:0] got_frame);
    logic [5:0]  ridx;
    logic        dir;
    logic [39:0] body;
    logic [47:0] word, exp_frame;
    bit          to_exp, crc_exp, idx_exp;
    int          n, budget, d0;
    ridx = idx;
    dir  = 1'b0;
    if (mode == 3) ridx = idx ^ 6'h01;
    if (mode == 5) begin
      ridx = 6'($urandom);
      dir  = 1'($urandom);
    end
    body = {1'b0, dir, ridx, rarg_in};
    word = {body, crc_model(body), 1'b1};
    if (mode == 2) word[7:1] = word[7:1] ^ 7'($urandom_range(1, 127));
    if (mode == 4) word[0] = 1'b0;
    resp_armed = !skip && (mode != 1);
    resp_word  = word;
    resp_delay = $urandom_range(0, 8);
    tx_q.delete();
    exp_frame = {2'b01, idx, arg, crc_model({2'b01, idx, arg}), 1'b1};
    budget    = 300 * div + 400;

    start = 1'b1; cmd_index = idx; cmd_arg = arg; cmd_skip = skip;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);

    if (poke) begin
      n = 0;
      while (tx_q.size() < 10 && n < budget) begin tick(); n++; end
      start = 1'b1; cmd_index = ~idx; cmd_arg = ~arg; cmd_skip = ~skip;
      tick();
      start = 1'b0;
    end
    if (stall) begin
      n = 0;
      while (!(tx_q.size() == 48 && !cmd_oe) && n < budget) begin tick(); n++; end
      clk_run = 1'b0;
      d0 = done_seen;
      repeat (300) tick();
      check("stall_busy", busy, 1);
      check("stall_no_timeout", tmo, 0);
      check("stall_no_done", done_seen, d0);
      ph = 0;
      clk_run = 1'b1;
    end

    n = 0;
    while (!done && n < budget) begin tick(); n++; end
    if (!done) begin
      check("done_wait", 0, 1);
      return;
    end
    got_frame = '0;
    foreach (tx_q[i]) got_frame = {got_frame[46:0], tx_q[i]};
    check("tx_bit_count", tx_q.size(), 48);
    check("tx_frame", got_frame, exp_frame);

    to_exp  = !skip && (mode == 1);
    crc_exp = 1'b0;
    idx_exp = 1'b0;
    if (!skip && mode != 1) begin
      exp_ri  = word[45:40];
      exp_ra  = word[39:8];
      crc_exp = !word[0] || (CRC_EN && (crc_model(word[47:8]) != word[7:1]));
      idx_exp = (word[45:40] != idx);
    end
    check("timeout", tmo, to_exp);
    check("crc_error", crc_err, crc_exp);
    check("index_error", idx_err, idx_exp);
    check("resp_index", resp_index, exp_ri);
    check("resp_arg", resp_arg, exp_ra);
    check("busy_at_done", busy, 0);
    check("oe_at_done", cmd_oe, 0);
    if (skip)      check("gap_len", rise_since_rel, 8);
    else if (to_exp) check("timeout_len", rise_since_rel, 64 + 8);
    tick();
    check("done_pulse_len", done, 0);
  endtask

  initial begin
    logic [47:0] f, f_ref;
    int          n, d0;
    repeat (3) tick();
    check("rst_oe", cmd_oe, 0);
    check("rst_out", cmd_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {tmo, crc_err, idx_err}, 0);
    check("rst_resp", {resp_index, resp_arg}, 0);
    reset = 1'b0;
    tick();

    run_cmd(6'd0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 32'h0, f);
    check("cmd0_vector", f, 48'h40_0000_0000_95);
    run_cmd(6'd8, 32'h1AA, 1'b0, 0, 1'b0, 1'b0, 32'h1AA, f);
    check("cmd8_vector", f, 48'h48_0000_01AA_87);
    f_ref = f;
    run_cmd(6'd8, 32'h1AA, 1'b0, 1, 1'b0, 1'b1, 32'h1AA, f);
    run_cmd(6'd8, 32'h1AA, 1'b0, 2, 1'b0, 1'b0, 32'h1AA, f);
    run_cmd(6'd8, 32'h1AA, 1'b0, 3, 1'b0, 1'b0, 32'h1AA, f);
    run_cmd(6'd8, 32'h1AA, 1'b0, 4, 1'b0, 1'b0, 32'h1AA, f);
    run_cmd(6'd8, 32'h1AA, 1'b0, 0, 1'b1, 1'b0, 32'hC0FFEE01, f);

    // Abort mid-frame with reset.
    resp_armed = 1'b0;
    tx_q.delete();
    start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h1AA; cmd_skip = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (tx_q.size() < 20 && n < 2000) begin tick(); n++; end
    check("reached_bit20", tx_q.size() >= 20, 1);
    d0 = done_seen;
    reset = 1'b1;
    tick();
    check("abort_oe", cmd_oe, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    exp_ri = '0;
    exp_ra = '0;
    repeat (200) tick();
    check("abort_no_done", done_seen, d0);
    check("abort_out", cmd_out, 1);
    run_cmd(6'd0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 32'h0, f);
    check("cmd0_after_abort", f, 48'h40_0000_0000_95);

    div = 256; ph = 0;
    run_cmd(6'd8, 32'h1AA, 1'b0, 0, 1'b0, 1'b0, 32'h1AA, f);
    check("div256_same_bits", f, f_ref);

    for (int k = 0; k < 20; k++) begin
      div = $urandom_range(2, 7);
      ph  = 0;
      run_cmd(6'($urandom), $urandom, 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 5), 1'($urandom_range(0, 4) == 0), 1'b0, $urandom, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
